// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared types and constants for the WB-stage flush/redirect controller.
// Controller state encoding, event classes and default vector addresses.
package flush_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_DRAIN,
    ST_REDIR
  } ctrl_state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_ERET,
    EV_REFETCH
  } ev_class_t;

  localparam logic [31:0] EXC_ENTRY_DEFAULT    = 32'hbfc00380;
  localparam logic [31:0] REFILL_ENTRY_DEFAULT = 32'hbfc00200;

  // Exceptions beat ERET, which beats a TLBR/TLBWI refetch.
  function automatic ev_class_t classify_event(input logic ex,
                                               input logic eret,
                                               input logic tlbrw);
    ev_class_t cls;
    cls = EV_NONE;
    if (ex)
      cls = EV_EXC;
    else if (eret)
      cls = EV_ERET;
    else if (tlbrw)
      cls = EV_REFETCH;
    return cls;
  endfunction

endpackage

// File: rtl/flush_redirect_ctrl_ost_counter.sv
// Saturating up/down counter of outstanding instruction-bus reads.
// Exposes the next value so the controller can decide in the same cycle.
module ost_counter #(
  parameter int OST_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [OST_W-1:0] count_next,
  output logic             zero
);

  localparam logic [OST_W-1:0] MAX_COUNT = {OST_W{1'b1}};

  logic [OST_W-1:0] count;

  // Simultaneous request and response cancel out; both ends clamp.
  always_comb begin
    count_next = count;
    if (inc && !dec) begin
      if (count != MAX_COUNT)
        count_next = count + OST_W'(1);
    end else if (dec && !inc) begin
      if (count != '0)
        count_next = count - OST_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else
      count <= count_next;
  end

  assign zero = (count == '0);

  ovf_check: assert property (@(posedge clk) disable iff (reset)
                              !(inc && !dec && count == MAX_COUNT));

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Flush, drain and redirect sequencer for WB-stage control-flow events.
// Optional event statistics are built when FLUSH_CTRL_STATS_EN is defined.
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter int          OST_W        = 3,
  parameter logic [31:0] EXC_ENTRY    = EXC_ENTRY_DEFAULT,
  parameter logic [31:0] REFILL_ENTRY = REFILL_ENTRY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_ex,
  input  logic        ws_tlb_refill,
  input  logic        ws_eret,
  input  logic        ws_tlbrw,
  input  logic [31:0] refetch_pc,
  input  logic [31:0] cp0_epc,
  input  logic        inst_req_hs,
  input  logic        inst_rsp_hs,
  output logic        flush,
  output logic        fetch_hold,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
`ifdef FLUSH_CTRL_STATS_EN
  ,
  output logic [31:0] stat_exc,
  output logic [31:0] stat_eret,
  output logic [31:0] stat_refetch
`endif
);

  ctrl_state_t      state;
  ev_class_t        ev_class;
  logic [31:0]      event_target;
  logic [OST_W-1:0] ost_next;
  logic             ost_zero;

  ost_counter #(
    .OST_W (OST_W)
  ) u_ost (
    .clk        (clk),
    .reset      (reset),
    .inc        (inst_req_hs),
    .dec        (inst_rsp_hs),
    .count_next (ost_next),
    .zero       (ost_zero)
  );

  always_comb begin
    ev_class     = classify_event(ws_ex, ws_eret, ws_tlbrw);
    event_target = '0;
    unique case (ev_class)
      EV_EXC:     event_target = ws_tlb_refill ? REFILL_ENTRY : EXC_ENTRY;
      EV_ERET:    event_target = cp0_epc;
      EV_REFETCH: event_target = refetch_pc;
      default:    event_target = '0;
    endcase
  end

  // Outputs are registered alongside the state so each is a clean Moore signal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      flush          <= 1'b0;
      fetch_hold     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ev_class != EV_NONE) begin
            state       <= ST_FLUSH;
            flush       <= 1'b1;
            fetch_hold  <= 1'b1;
            busy        <= 1'b1;
            redirect_pc <= event_target;
          end
        end
        ST_FLUSH: begin
          flush <= 1'b0;
          if (ost_next != '0) begin
            state <= ST_DRAIN;
          end else begin
            state          <= ST_REDIR;
            fetch_hold     <= 1'b0;
            redirect_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (ost_zero) begin
            state          <= ST_REDIR;
            fetch_hold     <= 1'b0;
            redirect_valid <= 1'b1;
          end
        end
        ST_REDIR: begin
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          flush          <= 1'b0;
          fetch_hold     <= 1'b0;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLUSH_CTRL_STATS_EN
  // Only events accepted in IDLE are counted; ignored ones never reach here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_exc     <= '0;
      stat_eret    <= '0;
      stat_refetch <= '0;
    end else if (state == ST_IDLE) begin
      if (ev_class == EV_EXC)
        stat_exc <= stat_exc + 32'd1;
      if (ev_class == EV_ERET)
        stat_eret <= stat_eret + 32'd1;
      if (ev_class == EV_REFETCH)
        stat_refetch <= stat_refetch + 32'd1;
    end
  end
`endif

endmodule

// File: doc/flush_redirect_ctrl.md
Name: flush_redirect_ctrl

Overview:
- Sequences pipeline flush and front-end redirect for every WB-stage event that changes control flow: exception, TLB-refill exception, ERET, and TLBR/TLBWI refetch.
- Sits beside CP0 and takes its event strobes from the WB stage.
- Drives a flush to all stages, then holds fetch until all outstanding instruction-bus reads have drained.
- Then hands a single redirect PC to pre-IF with a valid/ready handshake.

Parameters:
- OST_W, 3, width of the outstanding instruction-read counter (max 2^OST_W-1 in flight)
- EXC_ENTRY, 32'hbfc00380, general exception vector
- REFILL_ENTRY, 32'hbfc00200, TLB-refill vector

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ws_ex  in  1  WB exception, already qualified by WB valid
- ws_tlb_refill  in  1  WB exception is a TLB refill (meaningful with ws_ex)
- ws_eret  in  1  WB ERET, qualified
- ws_tlbrw  in  1  WB TLBR/TLBWI, qualified; requires refetch
- refetch_pc  in  32  WB pc+4
- cp0_epc  in  32  current CP0 EPC
- inst_req_hs  in  1  instruction read address handshake (arvalid&arready, id=instr)
- inst_rsp_hs  in  1  instruction read data handshake (rvalid&rready&rlast, id=instr)
- flush  out  1  kill all stage valids and discard fetch results
- fetch_hold  out  1  pre-IF must not issue new requests
- redirect_valid  out  1  redirect PC offered
- redirect_pc  out  32  next fetch PC
- redirect_ready  in  1  pre-IF accepts redirect
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, FLUSH, DRAIN, REDIR. Reset: IDLE, counter 0, redirect_pc 0, all outputs 0.
- Event in IDLE: event = ws_ex|ws_eret|ws_tlbrw. Priority ws_ex > ws_eret > ws_tlbrw.
- Target PC, latched in the event cycle:
  - ws_ex&ws_tlb_refill -> REFILL_ENTRY
  - ws_ex otherwise -> EXC_ENTRY
  - ws_eret -> cp0_epc as sampled that cycle
  - ws_tlbrw -> refetch_pc
- IDLE -> FLUSH on an event.
- FLUSH (exactly 1 cycle): flush=1, fetch_hold=1. Next state is DRAIN if the counter's next value is nonzero, else REDIR.
- DRAIN: fetch_hold=1, flush=0. Stays until the counter reaches 0; transitions the cycle after the counter reads 0.
- REDIR: redirect_valid=1, fetch_hold=0. redirect_pc is stable while valid. On redirect_ready -> IDLE in the same edge.
- flush is Moore, asserted only in FLUSH. fetch_hold=1 in FLUSH and DRAIN. busy=1 in all non-IDLE states.
- Minimum latency, counter 0 and ready tied high: event at cycle N -> flush N+1 -> redirect_valid N+2 -> IDLE N+3.
- Events while not IDLE are ignored. The flush kills their source; the bench flags any such event as a protocol error only under assertions.
- Outstanding counter, updated in all states:
  - +1 on req_hs alone; -1 on rsp_hs alone; unchanged when both are asserted.
  - Decrement at 0 is ignored.
  - Increment at max saturates, and an assertion fires.
- Requests accepted in the FLUSH cycle are counted, and their data is drained.
- Asynchronous reset mid-operation: immediate return to IDLE, counter cleared, all outputs 0.
- Redirect handshake: a new event cannot occur in the handshake cycle, because the pipeline is empty.

Optional Feature:
- Macro FLUSH_CTRL_STATS_EN.
- Defined: adds outputs stat_exc, stat_eret and stat_refetch (32 bits each, wrapping). Each increments once per accepted IDLE event of its class. All are cleared by reset.
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package/header (mycpu.h): state encoding macros, EXC_ENTRY/REFILL_ENTRY default constants, event-class encoding.
- One natural sub-module, ost_counter: saturating up/down counter with zero flag, parameterised by OST_W.

Test Plan:
- ws_ex=1, ws_tlb_refill=0, counter 0, redirect_ready=1: flush pulse 1 cycle, redirect_pc=32'hbfc00380 two cycles after the event, busy low on the following cycle.
- ws_ex=1 and ws_tlb_refill=1 asserted together with ws_tlbrw=1, refetch_pc=32'h8000_1004: exception wins, redirect_pc=32'hbfc00200.
- Two inst_req_hs before the event plus one during FLUSH, then rsp_hs at +3, +5, +9: fetch_hold stays 1 through the +9 response, and redirect_valid rises the cycle after the counter reads 0.
- ws_eret with cp0_epc=32'hbfc0_1234, redirect_ready low for 4 cycles: redirect_valid and redirect_pc stay stable, and IDLE is entered on the ready edge.
- Async reset asserted in DRAIN with counter=2: outputs 0 immediately, and post-reset ws_tlbrw with refetch_pc=32'h8000_0010 redirects with a counter of 0.
- Simultaneous req_hs and rsp_hs at counter 1: counter unchanged; rsp_hs at counter 0 leaves the counter at 0.
